// File: rtl/riscv_v_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : riscv_v_pkg
//  Description : Shared vector-unit sizing constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_v_pkg;

  // Vector register length in bits.
  localparam int VLEN = 128;

endpackage
`default_nettype wire

// File: rtl/vector_fp_writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module      : vector_fp_writeback_queue
//  Description : In-order result FIFO between the vector FP add pipeline and
//                the VRF write port. Results are captured with their vreg
//                index and byte enables, then drained with a valid/ready
//                handshake. Write-port stalls are absorbed here so the
//                fixed-latency add pipeline never sees back-pressure. A result
//                offered while the queue is full is dropped and flagged on the
//                sticky drop_error output.
//  Options     : VWB_PENDING_MAP_EN - adds the vreg_pending output, a
//                per-vreg "write still queued" map for RAW hazard checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_fp_writeback_queue
  import riscv_v_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         result_valid,
  output logic                         result_ready,
  input  logic [VLEN-1:0]              vd,
  input  logic [ADDR_WIDTH-1:0]        vd_addr,
  input  logic [VLEN/8-1:0]            vd_be,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [VLEN-1:0]              wb_data,
  output logic [ADDR_WIDTH-1:0]        wb_addr,
  output logic [VLEN/8-1:0]            wb_be,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         drop_error
`ifdef VWB_PENDING_MAP_EN
  ,
  output logic [2**ADDR_WIDTH-1:0]     vreg_pending
`endif
);

  localparam int BE_W  = VLEN / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Entry storage.
  logic [VLEN-1:0]       data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [BE_W-1:0]       be_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic push;
  logic pop;

  // Ready comes from the registered count alone, so a pop in the same cycle
  // never opens a slot combinationally (no wb_ready -> result_ready path).
  assign result_ready = (count != FULL_COUNT);
  assign wb_valid     = (count != '0);
  assign push         = result_valid && result_ready;
  assign pop          = wb_valid && wb_ready;

  // Head presentation: held steady by storage while stalled, zero when empty.
  assign wb_data = wb_valid ? data_mem[rd_ptr] : '0;
  assign wb_addr = wb_valid ? addr_mem[rd_ptr] : '0;
  assign wb_be   = wb_valid ? be_mem[rd_ptr]   : '0;

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_error <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (result_valid && !result_ready) begin
        drop_error <= 1'b1;
      end
    end
  end

  // Tail write on push; reset wipes every entry so no stale data survives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
        be_mem[i]   <= '0;
      end
    end else if (push) begin
      data_mem[wr_ptr] <= vd;
      addr_mem[wr_ptr] <= vd_addr;
      be_mem[wr_ptr]   <= vd_be;
    end
  end

`ifdef VWB_PENDING_MAP_EN
  // An entry is live when its distance from the head is below the count.
  logic [DEPTH-1:0] entry_live;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry_live
    assign entry_live[g] = (CNT_W'(PTR_W'(g) - rd_ptr) < count);
  end

  // OR of one-hot destination indices over all live entries.
  always_comb begin
    vreg_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_live[i]) begin
        vreg_pending[addr_mem[i]] = 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
